// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle MULT/MULTU/DIV/DIVU and MTHI/MTLO unit that owns the HI/LO registers.
// Define MDU_TRACE_EN to print a simulation line on every HI/LO update.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] D1,
    input  logic [31:0] D2,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LD = CW'(DIV_CYCLES - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [1:0]  op_q, op_d;

    logic        accept, done, res_wr, a_neg, b_neg;
    logic [31:0] ua, ub, bd, uq, ur, quo, rem;
    logic [63:0] prod_u, prod;

    // Signed ops run through one unsigned datapath on magnitudes, then fix the signs;
    // this makes 0x80000000 / -1 wrap to 0x80000000 naturally.
    assign a_neg  = ~op_q[0] & a_q[31];
    assign b_neg  = ~op_q[0] & b_q[31];
    assign ua     = a_neg ? -a_q : a_q;
    assign ub     = b_neg ? -b_q : b_q;
    assign bd     = (ub == '0) ? 32'd1 : ub;
    assign uq     = ua / bd;
    assign ur     = ua % bd;
    assign quo    = (a_neg ^ b_neg) ? -uq : uq;
    assign rem    = a_neg ? -ur : ur;
    assign prod_u = {32'd0, ua} * {32'd0, ub};
    assign prod   = (a_neg ^ b_neg) ? -prod_u : prod_u;

    assign accept = (state_q == IDLE) && start;
    assign done   = (state_q == BUSY) && (cnt_q == '0);
    assign res_wr = done && (!op_q[1] || b_q != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (accept && mdu_op < 3'd4) begin
            state_d = BUSY;
            cnt_d   = mdu_op[1] ? DIV_LD : MULT_LD;
            a_d     = D1;
            b_d     = D2;
            op_d    = mdu_op[1:0];
        end else if (accept) begin
            hi_d = (mdu_op == 3'd4) ? D1 : hi_q;
            lo_d = (mdu_op == 3'd5) ? D1 : lo_q;
        end else if (state_q == BUSY) begin
            state_d = done ? IDLE : BUSY;
            cnt_d   = done ? cnt_q : cnt_q - 1'b1;
        end
        if (res_wr) {hi_d, lo_d} = op_q[1] ? {rem, quo} : prod;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == BUSY);
    assign HI   = hi_q;
    assign LO   = lo_q;

`ifdef MDU_TRACE_EN
    function automatic string op_name(input logic [2:0] o);
        case (o)
            3'd0: return "MULT";
            3'd1: return "MULTU";
            3'd2: return "DIV";
            3'd3: return "DIVU";
            3'd4: return "MTHI";
            default: return "MTLO";
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset && (res_wr || (accept && (mdu_op == 3'd4 || mdu_op == 3'd5))))
            $display("%0t mdu %s HI=%08h LO=%08h", $time,
                     res_wr ? op_name({1'b0, op_q}) : op_name(mdu_op), hi_d, lo_d);
    end
`endif
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed-vector bench for mult_div_unit with hand-computed HI/LO results.
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  mdu_op = 3'd0;
    logic [31:0] D1 = '0;
    logic [31:0] D2 = '0;
    logic        busy;
    logic [31:0] HI, LO;

    int vectors = 0;
    int errors = 0;

    mult_div_unit dut (
        .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
        .D1(D1), .D2(D2), .busy(busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    // Present one op for a single edge, then scramble operands to prove they were latched.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        mdu_op = op;
        D1 = a;
        D2 = b;
        @(negedge clk);
        start = 1'b0;
        D1 = ~a;
        D2 = ~b + 32'd5;
    endtask

    // Counts negedges with busy high; held=0 if HI/LO moved while busy.
    task automatic wait_idle(output int n, output logic held);
        logic [31:0] h0, l0;
        h0 = HI;
        l0 = LO;
        n = 0;
        held = 1'b1;
        while (busy === 1'b1 && n < 100) begin
            if (HI !== h0 || LO !== l0) held = 1'b0;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        #2;
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (HI !== 32'd0) begin errors++; $display("FAIL reset_hi got %08h want 00000000", HI); end
        vectors++; if (LO !== 32'd0) begin errors++; $display("FAIL reset_lo got %08h want 00000000", LO); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_mult;
        int n;
        logic held;
        issue(3'd0, 32'hFFFFFFFE, 32'd3);
        wait_idle(n, held);
        vectors++; if (n !== 5) begin errors++; $display("FAIL mult_cycles got %0d want 5", n); end
        vectors++; if (held !== 1'b1) begin errors++; $display("FAIL mult_hold got %b want 1", held); end
        vectors++; if (HI !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %08h want ffffffff", HI); end
        vectors++; if (LO !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_lo got %08h want fffffffa", LO); end
        issue(3'd1, 32'hFFFFFFFE, 32'd3);
        wait_idle(n, held);
        vectors++; if (n !== 5) begin errors++; $display("FAIL multu_cycles got %0d want 5", n); end
        vectors++; if (HI !== 32'h00000002) begin errors++; $display("FAIL multu_hi got %08h want 00000002", HI); end
        vectors++; if (LO !== 32'hFFFFFFFA) begin errors++; $display("FAIL multu_lo got %08h want fffffffa", LO); end
    endtask

    task automatic test_div;
        int n;
        logic held;
        issue(3'd2, 32'hFFFFFFF9, 32'd2);
        wait_idle(n, held);
        vectors++; if (n !== 10) begin errors++; $display("FAIL div_cycles got %0d want 10", n); end
        vectors++; if (held !== 1'b1) begin errors++; $display("FAIL div_hold got %b want 1", held); end
        vectors++; if (LO !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo got %08h want fffffffd", LO); end
        vectors++; if (HI !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi got %08h want ffffffff", HI); end
        issue(3'd3, 32'd7, 32'd2);
        wait_idle(n, held);
        vectors++; if (LO !== 32'd3) begin errors++; $display("FAIL divu_lo got %08h want 00000003", LO); end
        vectors++; if (HI !== 32'd1) begin errors++; $display("FAIL divu_hi got %08h want 00000001", HI); end
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(n, held);
        vectors++; if (LO !== 32'h80000000) begin errors++; $display("FAIL divovf_lo got %08h want 80000000", LO); end
        vectors++; if (HI !== 32'h00000000) begin errors++; $display("FAIL divovf_hi got %08h want 00000000", HI); end
    endtask

    task automatic test_mt_div0;
        int n;
        logic held;
        issue(3'd4, 32'h12345678, 32'd0);
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %b want 0", busy); end
        vectors++; if (HI !== 32'h12345678) begin errors++; $display("FAIL mthi_hi got %08h want 12345678", HI); end
        vectors++; if (LO !== 32'h80000000) begin errors++; $display("FAIL mthi_lo got %08h want 80000000", LO); end
        issue(3'd3, 32'd99, 32'd0);
        start = 1'b1;
        mdu_op = 3'd5;
        D1 = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0;
        wait_idle(n, held);
        vectors++; if (n + 1 !== 10) begin errors++; $display("FAIL div0_cycles got %0d want 10", n + 1); end
        vectors++; if (HI !== 32'h12345678) begin errors++; $display("FAIL div0_hi got %08h want 12345678", HI); end
        vectors++; if (LO !== 32'h80000000) begin errors++; $display("FAIL div0_lo got %08h want 80000000", LO); end
    endtask

    task automatic test_back_to_back;
        issue(3'd0, 32'd2, 32'd3);
        repeat (4) @(negedge clk);
        start = 1'b1;
        mdu_op = 3'd4;
        D1 = 32'hCAFEF00D;
        @(negedge clk);
        start = 1'b0;
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL fall_busy got %b want 0", busy); end
        vectors++; if (HI !== 32'd0) begin errors++; $display("FAIL fall_hi got %08h want 00000000", HI); end
        vectors++; if (LO !== 32'd6) begin errors++; $display("FAIL fall_lo got %08h want 00000006", LO); end
        issue(3'd6, 32'h11111111, 32'h22222222);
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rsvd_busy got %b want 0", busy); end
        vectors++; if (HI !== 32'd0 || LO !== 32'd6) begin errors++; $display("FAIL rsvd_hilo got %08h_%08h want 00000000_00000006", HI, LO); end
    endtask

    task automatic test_reset_abort;
        issue(3'd0, 32'hFFFFFFFE, 32'd3);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        vectors++; if (HI !== 32'd0 || LO !== 32'd0) begin errors++; $display("FAIL abort_hilo got %08h_%08h want 00000000_00000000", HI, LO); end
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        vectors++; if (HI !== 32'd0 || LO !== 32'd0 || busy !== 1'b0) begin errors++; $display("FAIL abort_nowrite got %08h_%08h busy %b want 00000000_00000000 busy 0", HI, LO, busy); end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        mdu_op = 3'd5;
        D1 = 32'hA5A5A5A5;
        @(negedge clk);
        start = 1'b0;
        vectors++; if (LO !== 32'hA5A5A5A5) begin errors++; $display("FAIL release_mtlo got %08h want a5a5a5a5", LO); end
        vectors++; if (HI !== 32'd0) begin errors++; $display("FAIL release_hi got %08h want 00000000", HI); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mt_div0();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
